// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
// Optional build macro: BRAM_ARB_STATS_EN adds per-requester grant counters.
package bram_arb_pkg;

    // Upper bound on requester count and the grant-index width that covers it
    localparam int unsigned REQ_MAX = 4;
    localparam int unsigned IDX_W   = $clog2(REQ_MAX);

`ifdef BRAM_ARB_STATS_EN
    localparam int unsigned STAT_W = 32;
`endif

    // Per-requester transaction state
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_RESP_HOLD = 2'd2
    } req_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible requester after the last grant wins.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant_c
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // Scan requesters in rotated order starting one past the last grant
    always_comb begin
        o_grant_c = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(i_last_grant) + k) % NUM_REQ);
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_eligible[j] && (w_cand == IDX_W'(j))) begin
                    o_grant_c[j] = 1'b1;
                    w_found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 1R/1W byte-enabled BRAM among NUM_REQ requesters.
// Optional build macro: BRAM_ARB_STATS_EN adds o_grant_count (saturating per-requester accepts).
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    output logic [NUM_REQ-1:0]               o_req_ready,
    input  logic [NUM_REQ-1:0]               i_req_write,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  i_req_byte_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
    output logic [NUM_REQ-1:0]               o_resp_valid,
    input  logic [NUM_REQ-1:0]               i_resp_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    o_resp_rdata,
    output logic                             o_mem_read_enable,
    output logic [ADDR_WIDTH-1:0]            o_mem_read_address,
    input  logic [DATA_WIDTH-1:0]            i_mem_read_data,
    output logic                             o_mem_write_enable,
    output logic [DATA_WIDTH/8-1:0]          o_mem_write_byte_en,
    output logic [ADDR_WIDTH-1:0]            o_mem_write_address,
    output logic [DATA_WIDTH-1:0]            o_mem_write_data
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]        o_grant_count
`endif
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    req_state_e                    r_state     [NUM_REQ];
    req_state_e                    w_state_nxt [NUM_REQ];
    logic [IDX_W-1:0]              r_last_grant;
    logic [NUM_REQ*DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REQ-1:0]            w_eligible;
    logic [NUM_REQ-1:0]            w_grant;
    logic [IDX_W-1:0]              w_gidx;
    logic                          w_accept;

    // Only idle requesters compete; nothing is granted while reset is asserted
    always_comb begin
        w_eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = i_rst_n && i_req_valid[i] && (r_state[i] == ST_IDLE);
        end
    end

    rr_arbiter #(
        .NUM_REQ      (NUM_REQ)
    ) u_rr_arbiter (
        .i_eligible   (w_eligible),
        .i_last_grant (r_last_grant),
        .o_grant_c    (w_grant)
    );

    // Encode the one-hot grant into an index for the round-robin pointer
    always_comb begin
        w_gidx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = IDX_W'(i);
            end
        end
    end

    assign w_accept    = |w_grant;
    assign o_req_ready = w_grant;

    // Route the granted request onto the read or write BRAM port
    always_comb begin
        o_mem_read_enable   = 1'b0;
        o_mem_read_address  = '0;
        o_mem_write_enable  = 1'b0;
        o_mem_write_byte_en = '0;
        o_mem_write_address = '0;
        o_mem_write_data    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                if (i_req_write[i]) begin
                    o_mem_write_enable  = 1'b1;
                    o_mem_write_byte_en = i_req_byte_en[i*BE_W +: BE_W];
                    o_mem_write_address = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    o_mem_write_data    = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    o_mem_read_enable   = 1'b1;
                    o_mem_read_address  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    // Per-requester next state: reads wait one cycle for data, then hold until consumed
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE:      if (w_grant[i] && !i_req_write[i]) w_state_nxt[i] = ST_WAIT_DATA;
                ST_WAIT_DATA: w_state_nxt[i] = ST_RESP_HOLD;
                ST_RESP_HOLD: if (i_resp_ready[i]) w_state_nxt[i] = ST_IDLE;
                default:      w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    // Per-requester state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) r_state[i] <= ST_IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    // Round-robin pointer moves only when a request is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last_grant <= w_gidx;
        end
    end

    // Capture BRAM read data in the cycle after the read was issued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (r_state[i] == ST_WAIT_DATA) begin
                    r_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= i_mem_read_data;
                end
            end
        end
    end

    // Response valid is a pure decode of the held state
    always_comb begin
        o_resp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            o_resp_valid[i] = (r_state[i] == ST_RESP_HOLD);
        end
    end

    assign o_resp_rdata = r_rdata;

`ifdef BRAM_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] r_grant_count;

    // Saturating accept counters, one per requester
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && (r_grant_count[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                    r_grant_count[i*STAT_W +: STAT_W] <= r_grant_count[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign o_grant_count = r_grant_count;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter (2 requesters, 32-bit data, 8-bit address).
// Build with BRAM_ARB_STATS_EN defined to also exercise the grant counters.
module tb_bram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [7:0]  req_be;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_rdata;
    logic        mem_re;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_wbe;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
`ifdef BRAM_ARB_STATS_EN
    logic [63:0] grant_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];

    bram_port_arbiter #(
        .NUM_REQ    (2),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_req_valid         (req_valid),
        .o_req_ready         (req_ready),
        .i_req_write         (req_write),
        .i_req_byte_en       (req_be),
        .i_req_addr          (req_addr),
        .i_req_wdata         (req_wdata),
        .o_resp_valid        (resp_valid),
        .i_resp_ready        (resp_ready),
        .o_resp_rdata        (resp_rdata),
        .o_mem_read_enable   (mem_re),
        .o_mem_read_address  (mem_raddr),
        .i_mem_read_data     (mem_rdata),
        .o_mem_write_enable  (mem_we),
        .o_mem_write_byte_en (mem_wbe),
        .o_mem_write_address (mem_waddr),
        .o_mem_write_data    (mem_wdata)
`ifdef BRAM_ARB_STATS_EN
        ,
        .o_grant_count       (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: contents reloaded while reset is low, 1-cycle read latency
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 256; a++) mem[a] <= 32'h1000_0000 | 32'(a);
            mem[8'h05] <= 32'hDEAD_BEEF;
            mem[8'h10] <= 32'hAAAA_AAAA;
            mem_rdata  <= '0;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wbe[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
            if (mem_re) mem_rdata <= mem[mem_raddr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic wr, input logic [7:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        req_valid[r]          = v;
        req_write[r]          = wr;
        req_addr[r*8 +: 8]    = a;
        req_be[r*4 +: 4]      = be;
        req_wdata[r*32 +: 32] = d;
    endtask

    logic [1:0] exp_rdy2 [6] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
    logic [1:0] exp_rv2  [6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
    logic [1:0] exp_rdy4 [7] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    logic [1:0] exp_rv4  [7] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};

    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_write  = 2'b00;
        req_be     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 2'b11;

        // Reset: outputs quiet even with requests pending
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(2'b00));
        chk("rst_resp_valid", 64'(resp_valid), 64'(2'b00));
        chk("rst_resp_rdata", resp_rdata, 64'h0);
        chk("rst_mem_enables", 64'({mem_re, mem_we}), 64'(2'b00));
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single read, 2-cycle response latency
        tick();
        set_req(0, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0);
        #1;
        chk("t1_ready", 64'(req_ready), 64'(2'b01));
        chk("t1_ren", 64'(mem_re), 64'(1'b1));
        chk("t1_raddr", 64'(mem_raddr), 64'(8'h05));
        chk("t1_wen", 64'(mem_we), 64'(1'b0));
        tick();
        req_valid = 2'b00;
        chk("t1_rv_t1", 64'(resp_valid), 64'(2'b00));
        #1;
        chk("t1_ren_idle", 64'(mem_re), 64'(1'b0));
        tick();
        chk("t1_rv_t2", 64'(resp_valid), 64'(2'b01));
        chk("t1_rdata", 64'(resp_rdata[31:0]), 64'(32'hDEAD_BEEF));
        tick();
        chk("t1_rv_done", 64'(resp_valid), 64'(2'b00));

        // 2: both requesters read continuously, grants alternate
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t2_resp_valid", 64'(resp_valid), 64'(exp_rv2[c]));
            if (c == 2 || c == 5) chk("t2_rdata1", 64'(resp_rdata[63:32]), 64'(32'h1000_0021));
            if (c == 3) chk("t2_rdata0", 64'(resp_rdata[31:0]), 64'(32'h1000_0020));
            if (c == 0) begin
                set_req(0, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0);
                set_req(1, 1'b1, 1'b0, 8'h21, 4'h0, 32'h0);
            end
            #1;
            chk("t2_grant", 64'(req_ready), 64'(exp_rdy2[c]));
        end
        tick();
        req_valid = 2'b00;
        chk("t2_rv_tail", 64'(resp_valid), 64'(2'b01));
        tick();
        chk("t2_drained", 64'(resp_valid), 64'(2'b00));

        // 3: partial byte write then read-back; zero-enable write
        tick();
        set_req(1, 1'b1, 1'b1, 8'h10, 4'b0011, 32'h1234_5678);
        #1;
        chk("t3_ready_w", 64'(req_ready), 64'(2'b10));
        chk("t3_wen", 64'({mem_we, mem_re}), 64'(2'b10));
        chk("t3_wbe", 64'(mem_wbe), 64'(4'b0011));
        chk("t3_waddr", 64'(mem_waddr), 64'(8'h10));
        chk("t3_wdata", 64'(mem_wdata), 64'(32'h1234_5678));
        tick();
        set_req(1, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
        #1;
        chk("t3_ready_r", 64'(req_ready), 64'(2'b10));
        chk("t3_ren", 64'({mem_we, mem_re}), 64'(2'b01));
        chk("t3_raddr", 64'(mem_raddr), 64'(8'h10));
        tick();
        set_req(1, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        set_req(0, 1'b1, 1'b1, 8'h10, 4'h0, 32'hFFFF_FFFF);
        #1;
        chk("t3_ready_z", 64'(req_ready), 64'(2'b01));
        chk("t3_wen_z", 64'({mem_we, mem_re}), 64'(2'b10));
        chk("t3_wbe_z", 64'(mem_wbe), 64'(4'b0000));
        tick();
        req_valid = 2'b00;
        chk("t3_rv", 64'(resp_valid), 64'(2'b10));
        chk("t3_rdata1", 64'(resp_rdata[63:32]), 64'(32'hAAAA_5678));
        tick();
        chk("t3_drained", 64'(resp_valid), 64'(2'b00));

        // 4: back-pressure on requester 0 while requester 1 keeps being served
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("t4_resp_valid", 64'(resp_valid), 64'(exp_rv4[c]));
            if (c >= 2) chk("t4_rdata0_held", 64'(resp_rdata[31:0]), 64'(32'h1000_0030));
            if (c == 3) chk("t4_rdata1", 64'(resp_rdata[63:32]), 64'(32'h1000_0031));
            if (c == 0) begin
                resp_ready = 2'b10;
                set_req(0, 1'b1, 1'b0, 8'h30, 4'h0, 32'h0);
            end
            if (c == 1) set_req(1, 1'b1, 1'b0, 8'h31, 4'h0, 32'h0);
            #1;
            chk("t4_grant", 64'(req_ready), 64'(exp_rdy4[c]));
        end
        tick();
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        chk("t4_rv_release", 64'(resp_valid), 64'(2'b01));
        tick();
        chk("t4_drained", 64'(resp_valid), 64'(2'b00));

        // 5: reset while a read is in flight discards it
        tick();
        set_req(0, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0);
        #1;
        chk("t5_ready", 64'(req_ready), 64'(2'b01));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rv", 64'(resp_valid), 64'(2'b00));
        chk("t5_rst_ready", 64'(req_ready), 64'(2'b00));
        chk("t5_rst_rdata", resp_rdata, 64'h0);
        chk("t5_rst_ren", 64'(mem_re), 64'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_no_stale", 64'(resp_valid), 64'(2'b00));
        end
        tick();
        set_req(0, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 8'h31, 4'h0, 32'h0);
        #1;
        chk("t5_req0_first", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        tick();
        chk("t5_rv_after", 64'(resp_valid), 64'(2'b01));
        chk("t5_rdata_after", 64'(resp_rdata[31:0]), 64'(32'hDEAD_BEEF));
        tick();

`ifdef BRAM_ARB_STATS_EN
        // 6: accept counters after 3 + 2 write grants
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_cnt_reset", grant_count, 64'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin
                set_req(0, 1'b1, 1'b1, 8'h40, 4'hF, 32'h0);
                set_req(1, 1'b1, 1'b1, 8'h41, 4'hF, 32'h0);
            end
            #1;
            chk("t6_grant", 64'(req_ready), ((c % 2) == 0) ? 64'(2'b01) : 64'(2'b10));
        end
        tick();
        req_valid = 2'b00;
        chk("t6_counts", grant_count, {32'd2, 32'd3});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
